wb_dsp_scoreboard: RTL and testbench

Synthesizable self-checking scoreboard for wb_dsp benches.
- Stimulus side pushes expected results into an internal FIFO; the DUT-monitor side presents measured results.
- Compares in order, counts tests and mismatches, and drives the bench-level test_passed / test_failed flags.
- Sits directly upstream of the bench pass/fail reporting; replaces per-call compare bookkeeping with a cycle-accurate checker.

---
 rtl/wb_dsp_scoreboard_pkg.sv | 28 ++
 rtl/wb_dsp_sync_fifo.sv | 57 +++++
 rtl/wb_dsp_scoreboard.sv | 152 +++++++++++++++
 tb/tb_wb_dsp_scoreboard.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dsp_scoreboard_pkg.sv
// Shared constants for the wb_dsp scoreboard: state and fail-cause encodings,
// the default test count, and a saturating counter helper.
package wb_dsp_scoreboard_pkg;

    localparam int unsigned NUMBER_OF_TESTS = 16;
    localparam int unsigned CNT_W           = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } sb_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE      = 3'd0,
        CAUSE_MISMATCH  = 3'd1,
        CAUSE_COUNT     = 3'd2,
        CAUSE_UNDERFLOW = 3'd3,
        CAUSE_TIMEOUT   = 3'd4
    } fail_cause_e;

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_dsp_sync_fifo.sv
// Synchronous first-word-fall-through FIFO holding {mask, data} entries.
// Ports: clk, rst (sync, active-high), flush (sync clear), push/din,
//        pop/dout (head always visible), full, empty.
// Pushes while full and pops while empty are dropped.
module wb_dsp_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Storage; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/wb_dsp_scoreboard.sv
// In-order self-checking scoreboard for wb_dsp benches.
// Expected words (with per-bit compare mask) are queued via exp_valid/exp_ready;
// each meas_valid pops the head and compares. Counts tests and mismatches,
// records the last mismatch, and produces a sticky pass/fail verdict on done,
// FIFO underflow or timeout.
// Ports: wb_clk/wb_rst, start/done pulses, exp_* push side, meas_* monitor side,
//        test_count/fail_count, mismatch pulse, mis_exp/mis_meas,
//        test_passed/test_failed, fail_cause.
module wb_dsp_scoreboard
    import wb_dsp_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter bit          MASK_EN        = 1'b1,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned NUM_TESTS      = NUMBER_OF_TESTS,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  start,
    input  logic                  done,
    input  logic                  exp_valid,
    output logic                  exp_ready,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [DATA_WIDTH-1:0] exp_mask,
    input  logic                  meas_valid,
    input  logic [DATA_WIDTH-1:0] meas_data,
    output logic [CNT_W-1:0]      test_count,
    output logic [CNT_W-1:0]      fail_count,
    output logic                  mismatch,
    output logic [DATA_WIDTH-1:0] mis_exp,
    output logic [DATA_WIDTH-1:0] mis_meas,
    output logic                  test_passed,
    output logic                  test_failed,
    output logic [2:0]            fail_cause
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    sb_state_e             state_q;
    fail_cause_e           fail_cause_q;
    logic [CNT_W-1:0]      test_count_q, test_count_d;
    logic [CNT_W-1:0]      fail_count_q, fail_count_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  mismatch_q;
    logic [DATA_WIDTH-1:0] mis_exp_q, mis_meas_q;
    logic                  passed_q, failed_q;

    logic [2*DATA_WIDTH-1:0] fifo_dout;
    logic                    fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0]   head_data, head_mask;
    logic                    in_run, do_cmp, underflow, miss, timeout_hit;

    wb_dsp_sync_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk),
        .rst   (wb_rst),
        .flush (start),
        .push  (in_run && exp_valid),
        .pop   (in_run && meas_valid),
        .din   ({exp_mask, exp_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Compare against the FIFO head; emptiness is the registered value, so a
    // same-cycle push never rescues an underflow.
    assign in_run    = (state_q == ST_RUN);
    assign head_data = fifo_dout[DATA_WIDTH-1:0];
    assign head_mask = MASK_EN ? fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH] : '1;
    assign do_cmp    = in_run && meas_valid && !fifo_empty;
    assign underflow = in_run && meas_valid && fifo_empty;
    assign miss      = do_cmp && (((head_data ^ meas_data) & head_mask) != '0);

    // Counter/timer next values; the done verdict looks at these so a compare
    // landing in the done cycle is included.
    assign test_count_d = do_cmp ? sat_inc(test_count_q) : test_count_q;
    assign fail_count_d = miss ? sat_inc(fail_count_q) : fail_count_q;
    assign timer_d      = timer_q + 1'b1;
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (timer_d == TMR_W'(TIMEOUT_CYCLES));

    // Verdict FSM with registered outputs.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q      <= ST_IDLE;
            fail_cause_q <= CAUSE_NONE;
            test_count_q <= '0;
            fail_count_q <= '0;
            timer_q      <= '0;
            mismatch_q   <= 1'b0;
            mis_exp_q    <= '0;
            mis_meas_q   <= '0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            if (start) begin
                state_q      <= ST_RUN;
                fail_cause_q <= CAUSE_NONE;
                test_count_q <= '0;
                fail_count_q <= '0;
                timer_q      <= '0;
                mis_exp_q    <= '0;
                mis_meas_q   <= '0;
                passed_q     <= 1'b0;
                failed_q     <= 1'b0;
            end else if (in_run) begin
                test_count_q <= test_count_d;
                fail_count_q <= fail_count_d;
                timer_q      <= timer_d;
                if (miss) begin
                    mismatch_q <= 1'b1;
                    mis_exp_q  <= head_data;
                    mis_meas_q <= meas_data;
                end
                // Priority: underflow, then done, then timeout.
                if (underflow) begin
                    state_q      <= ST_FAIL;
                    failed_q     <= 1'b1;
                    fail_cause_q <= CAUSE_UNDERFLOW;
                end else if (done) begin
                    if (test_count_d == CNT_W'(NUM_TESTS) && fail_count_d == '0) begin
                        state_q  <= ST_PASS;
                        passed_q <= 1'b1;
                    end else begin
                        state_q      <= ST_FAIL;
                        failed_q     <= 1'b1;
                        fail_cause_q <= (fail_count_d != '0) ? CAUSE_MISMATCH : CAUSE_COUNT;
                    end
                end else if (timeout_hit) begin
                    state_q      <= ST_FAIL;
                    failed_q     <= 1'b1;
                    fail_cause_q <= CAUSE_TIMEOUT;
                end
            end
        end
    end

    assign exp_ready   = !fifo_full;
    assign test_count  = test_count_q;
    assign fail_count  = fail_count_q;
    assign mismatch    = mismatch_q;
    assign mis_exp     = mis_exp_q;
    assign mis_meas    = mis_meas_q;
    assign test_passed = passed_q;
    assign test_failed = failed_q;
    assign fail_cause  = fail_cause_q;

endmodule

// File: tb/tb_wb_dsp_scoreboard.sv
// Bench for wb_dsp_scoreboard: table of single-compare vectors, directed
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_wb_dsp_scoreboard;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NT    = 4;
    localparam int unsigned TO    = 50;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic          wb_clk = 1'b0;
    logic          wb_rst, start, done, exp_valid, meas_valid;
    logic [DW-1:0] exp_data, exp_mask, meas_data;
    logic          exp_ready, mismatch, test_passed, test_failed;
    logic [15:0]   test_count, fail_count;
    logic [DW-1:0] mis_exp, mis_meas;
    logic [2:0]    fail_cause;

    int n_err    = 0;
    int n_checks = 0;

    always #5 wb_clk = ~wb_clk;

    wb_dsp_scoreboard #(
        .DATA_WIDTH     (DW),
        .MASK_EN        (1'b1),
        .FIFO_DEPTH     (DEPTH),
        .NUM_TESTS      (NT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .start       (start),
        .done        (done),
        .exp_valid   (exp_valid),
        .exp_ready   (exp_ready),
        .exp_data    (exp_data),
        .exp_mask    (exp_mask),
        .meas_valid  (meas_valid),
        .meas_data   (meas_data),
        .test_count  (test_count),
        .fail_count  (fail_count),
        .mismatch    (mismatch),
        .mis_exp     (mis_exp),
        .mis_meas    (mis_meas),
        .test_passed (test_passed),
        .test_failed (test_failed),
        .fail_cause  (fail_cause)
    );

    // ---------------- reference model ----------------
    int          m_phase;
    logic [63:0] m_q[$];
    int          m_tc, m_fc, m_cause, m_timer;
    bit          m_mis, m_pass, m_fail;
    logic [31:0] m_mexp, m_mmeas;

    task automatic model_clear();
        m_q.delete();
        m_tc = 0; m_fc = 0; m_cause = 0; m_timer = 0;
        m_mis = 0; m_pass = 0; m_fail = 0; m_mexp = 0; m_mmeas = 0;
    endtask

    task automatic model_fail(input int cause);
        m_phase = P_DONE; m_fail = 1; m_cause = cause;
    endtask

    task automatic model_step();
        bit          full_b, empty_b;
        logic [31:0] hd, hm;
        if (wb_rst) begin
            model_clear();
            m_phase = P_IDLE;
        end else begin
            m_mis = 0;
            if (start) begin
                model_clear();
                m_phase = P_RUN;
            end else if (m_phase == P_RUN) begin
                full_b  = (m_q.size() == DEPTH);
                empty_b = (m_q.size() == 0);
                if (meas_valid && empty_b) begin
                    model_fail(3);
                end else begin
                    if (meas_valid) begin
                        {hm, hd} = m_q.pop_front();
                        if (m_tc < 65535) m_tc++;
                        if (((hd ^ meas_data) & hm) != 0) begin
                            if (m_fc < 65535) m_fc++;
                            m_mis = 1; m_mexp = hd; m_mmeas = meas_data;
                        end
                    end
                    m_timer++;
                    if (done) begin
                        if (m_tc == NT && m_fc == 0) begin
                            m_phase = P_DONE; m_pass = 1;
                        end else begin
                            model_fail((m_fc != 0) ? 1 : 2);
                        end
                    end else if (TO != 0 && m_timer >= TO) begin
                        model_fail(4);
                    end
                end
                if (exp_valid && !full_b) m_q.push_back({exp_mask, exp_data});
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("m_exp_ready",  64'(exp_ready),   64'(m_q.size() != DEPTH));
        chk("m_test_count", 64'(test_count),  64'(m_tc));
        chk("m_fail_count", 64'(fail_count),  64'(m_fc));
        chk("m_mismatch",   64'(mismatch),    64'(m_mis));
        chk("m_mis_exp",    64'(mis_exp),     64'(m_mexp));
        chk("m_mis_meas",   64'(mis_meas),    64'(m_mmeas));
        chk("m_passed",     64'(test_passed), 64'(m_pass));
        chk("m_failed",     64'(test_failed), 64'(m_fail));
        chk("m_cause",      64'(fail_cause),  64'(m_cause));
        chk("excl_verdict", 64'(test_passed & test_failed), 64'd0);
    endtask

    task automatic tick();
        @(posedge wb_clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic clr();
        wb_rst = 0; start = 0; done = 0; exp_valid = 0; meas_valid = 0;
        exp_data = '0; exp_mask = '0; meas_data = '0;
    endtask

    task automatic do_start();
        clr(); start = 1; tick(); clr();
    endtask

    task automatic do_push(input logic [31:0] d, input logic [31:0] m);
        clr(); exp_valid = 1; exp_data = d; exp_mask = m; tick(); clr();
    endtask

    task automatic do_meas(input logic [31:0] d);
        clr(); meas_valid = 1; meas_data = d; tick(); clr();
    endtask

    task automatic do_done();
        clr(); done = 1; tick(); clr();
    endtask

    typedef struct {
        logic [31:0] e;
        logic [31:0] m;
        logic [31:0] s;
        bit          mis;
        logic [2:0]  cause;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEE, 1'b1, 3'd1};
        vecs[1] = '{32'h1234ABCD, 32'h0000FFFF, 32'hFFFFABCD, 1'b0, 3'd2};
        vecs[2] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 3'd2};
        vecs[3] = '{32'hA5A5A5A5, 32'h80000000, 32'h25A5A5A5, 1'b1, 3'd1};
        vecs[4] = '{32'hCAFEF00D, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b0, 3'd2};

        m_phase = P_IDLE;
        model_clear();
        clr();

        // Reset state
        wb_rst = 1; tick(); tick(); clr();
        chk("rst_exp_ready", 64'(exp_ready), 64'd1);
        chk("rst_test_count", 64'(test_count), 64'd0);
        chk("rst_passed", 64'(test_passed), 64'd0);
        chk("rst_failed", 64'(test_failed), 64'd0);
        chk("rst_cause", 64'(fail_cause), 64'd0);

        // IDLE ignores traffic
        clr(); exp_valid = 1; exp_data = 32'h5; exp_mask = '1; meas_valid = 1; tick(); clr();
        chk("idle_ignore_fail", 64'(test_failed), 64'd0);
        chk("idle_ignore_cnt", 64'(test_count), 64'd0);

        // Table: one compare then done
        for (int i = 0; i < 5; i++) begin
            do_start();
            do_push(vecs[i].e, vecs[i].m);
            do_meas(vecs[i].s);
            chk("tbl_mismatch", 64'(mismatch), 64'(vecs[i].mis));
            chk("tbl_test_count", 64'(test_count), 64'd1);
            chk("tbl_fail_count", 64'(fail_count), 64'(vecs[i].mis));
            if (vecs[i].mis) begin
                chk("tbl_mis_exp", 64'(mis_exp), 64'(vecs[i].e));
                chk("tbl_mis_meas", 64'(mis_meas), 64'(vecs[i].s));
            end
            do_done();
            chk("tbl_failed", 64'(test_failed), 64'd1);
            chk("tbl_cause", 64'(fail_cause), 64'(vecs[i].cause));
        end

        // Full pass with four matching words; later meas ignored
        do_start();
        do_push(32'h11, '1); do_push(32'h22, '1); do_push(32'h33, '1); do_push(32'h44, '1);
        do_meas(32'h11); do_meas(32'h22); do_meas(32'h33); do_meas(32'h44);
        do_done();
        chk("pass_passed", 64'(test_passed), 64'd1);
        chk("pass_failed", 64'(test_failed), 64'd0);
        chk("pass_count", 64'(test_count), 64'd4);
        chk("pass_fails", 64'(fail_count), 64'd0);
        chk("pass_cause", 64'(fail_cause), 64'd0);
        do_meas(32'h99);
        chk("pass_frozen", 64'(test_count), 64'd4);

        // Final compare in the same cycle as done still counts
        do_start();
        for (int i = 0; i < 4; i++) do_push(32'(i), '1);
        for (int i = 0; i < 3; i++) do_meas(32'(i));
        clr(); meas_valid = 1; meas_data = 32'd3; done = 1; tick(); clr();
        chk("samecyc_passed", 64'(test_passed), 64'd1);

        // Underflow
        do_start();
        do_meas(32'h1);
        chk("uflow_failed", 64'(test_failed), 64'd1);
        chk("uflow_cause", 64'(fail_cause), 64'd3);

        // 3 of 4 then done
        do_start();
        for (int i = 0; i < 3; i++) do_push(32'(i + 7), '1);
        for (int i = 0; i < 3; i++) do_meas(32'(i + 7));
        do_done();
        chk("short_cause", 64'(fail_cause), 64'd2);

        // Restart discards queued words -> underflow
        do_start();
        do_push(32'hA, '1); do_push(32'hB, '1);
        do_start();
        do_meas(32'hA);
        chk("restart_cause", 64'(fail_cause), 64'd3);

        // Fill FIFO, push against full, then pop+push
        do_start();
        for (int i = 1; i <= 9; i++) begin
            do_push(32'(i), '1);
            chk("fill_ready", 64'(exp_ready), 64'(i < 8));
        end
        clr(); meas_valid = 1; meas_data = 32'd1; exp_valid = 1; exp_data = 32'h99; exp_mask = '1; tick(); clr();
        chk("full_poppush_ready", 64'(exp_ready), 64'd1);
        clr(); meas_valid = 1; meas_data = 32'd2; exp_valid = 1; exp_data = 32'hAA; exp_mask = '1; tick(); clr();
        for (int i = 3; i <= 8; i++) do_meas(32'(i));
        do_meas(32'hAA);
        chk("drain_fails", 64'(fail_count), 64'd0);
        chk("drain_count", 64'(test_count), 64'd9);
        do_meas(32'h0);
        chk("drain_empty_cause", 64'(fail_cause), 64'd3);

        // Timeout at RUN cycle 50, then reset with busy inputs
        do_start();
        for (int i = 1; i < 50; i++) tick();
        chk("to_not_yet", 64'(test_failed), 64'd0);
        tick();
        chk("to_failed", 64'(test_failed), 64'd1);
        chk("to_cause", 64'(fail_cause), 64'd4);
        clr(); wb_rst = 1; start = 1; meas_valid = 1; exp_valid = 1; tick(); clr();
        chk("rst2_failed", 64'(test_failed), 64'd0);
        chk("rst2_cause", 64'(fail_cause), 64'd0);
        chk("rst2_ready", 64'(exp_ready), 64'd1);
        tick();
        chk("rst2_idle", 64'(test_count), 64'd0);

        // Randomized traffic against the model
        for (int r = 0; r < 40; r++) begin
            if (r % 10 == 9) begin
                clr(); wb_rst = 1; tick(); clr();
            end
            do_start();
            for (int c = 0; c < int'($urandom_range(5, 30)); c++) begin
                logic [31:0] masks [4];
                masks[0] = 32'hFFFFFFFF; masks[1] = 32'h1; masks[2] = 32'h2; masks[3] = 32'h0;
                clr();
                exp_valid  = ($urandom % 2) == 0;
                exp_data   = 32'($urandom_range(0, 3));
                exp_mask   = masks[$urandom_range(0, 3)];
                meas_valid = ($urandom % 3) == 0;
                meas_data  = 32'($urandom_range(0, 3));
                done       = ($urandom % 12) == 0;
                start      = ($urandom % 40) == 0;
                tick();
            end
            clr(); tick(); tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
